// File: rtl/xdn_ctrl_pkg.sv
// Shared opcodes, T-state encoding and control-word layout for the 8-bit bus CPU
// sequencer and its decoder.
package xdn_ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0    = 3'd0,
        T1    = 3'd1,
        T2    = 3'd2,
        T3    = 3'd3,
        T4    = 3'd4,
        THALT = 3'd7
    } tstate_e;

    // Every field is active-high; the top inverts the _n strobes on the way out.
    typedef struct packed {
        logic pc_count_enable;
        logic pc_jump;
        logic pc_output;
        logic mar_load;
        logic ram_load;
        logic ram_output;
        logic ir_load;
        logic ir_output;
        logic a_load;
        logic a_output;
        logic b_load;
        logic alu_output;
        logic alu_subtract;
        logic flags_load;
        logic out_load;
    } ctrl_word_t;

    function automatic tstate_e next_tstate(input tstate_e s, input logic last, input logic halt);
        if (s == THALT || halt)
            return THALT;
        if (last)
            return T0;
        return tstate_e'(s + 3'd1);
    endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational map from (T-state, opcode, flags) to the control word plus end-of-instruction.
// CONDITIONAL_JUMP_EN enables JC/JZ; otherwise they decode as NOP and the flags are ignored.
module control_decoder
    import xdn_ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4
) (
    input  tstate_e                 state,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    flag_carry,
    input  logic                    flag_zero,
    output ctrl_word_t              cw,
    output logic                    last,
    output logic                    halt
);

`ifndef CONDITIONAL_JUMP_EN
    logic unused_flags;
    assign unused_flags = flag_carry ^ flag_zero;
`endif

    always_comb begin
        cw   = '0;
        last = 1'b0;
        halt = 1'b0;
        case (state)
            T0: begin
                cw.pc_output = 1'b1;
                cw.mar_load  = 1'b1;
            end
            T1: begin
                cw.ram_output      = 1'b1;
                cw.ir_load         = 1'b1;
                cw.pc_count_enable = 1'b1;
            end
            T2: begin
                last = 1'b1;
                case (opcode)
                    OPCODE_WIDTH'(OP_LDA), OPCODE_WIDTH'(OP_ADD),
                    OPCODE_WIDTH'(OP_SUB), OPCODE_WIDTH'(OP_STA): begin
                        cw.ir_output = 1'b1;
                        cw.mar_load  = 1'b1;
                        last         = 1'b0;
                    end
                    OPCODE_WIDTH'(OP_LDI): begin
                        cw.ir_output = 1'b1;
                        cw.a_load    = 1'b1;
                    end
                    OPCODE_WIDTH'(OP_JMP): begin
                        cw.ir_output = 1'b1;
                        cw.pc_jump   = 1'b1;
                    end
`ifdef CONDITIONAL_JUMP_EN
                    OPCODE_WIDTH'(OP_JC): begin
                        cw.ir_output = flag_carry;
                        cw.pc_jump   = flag_carry;
                    end
                    OPCODE_WIDTH'(OP_JZ): begin
                        cw.ir_output = flag_zero;
                        cw.pc_jump   = flag_zero;
                    end
`endif
                    OPCODE_WIDTH'(OP_OUT): begin
                        cw.a_output = 1'b1;
                        cw.out_load = 1'b1;
                    end
                    OPCODE_WIDTH'(OP_HLT): begin
                        halt = 1'b1;
                        last = 1'b0;
                    end
                    default: ;
                endcase
            end
            T3: begin
                last = 1'b1;
                case (opcode)
                    OPCODE_WIDTH'(OP_LDA): begin
                        cw.ram_output = 1'b1;
                        cw.a_load     = 1'b1;
                    end
                    OPCODE_WIDTH'(OP_ADD), OPCODE_WIDTH'(OP_SUB): begin
                        cw.ram_output = 1'b1;
                        cw.b_load     = 1'b1;
                        last          = 1'b0;
                    end
                    OPCODE_WIDTH'(OP_STA): begin
                        cw.a_output = 1'b1;
                        cw.ram_load = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                last = 1'b1;
                if (opcode == OPCODE_WIDTH'(OP_ADD) || opcode == OPCODE_WIDTH'(OP_SUB)) begin
                    cw.alu_output   = 1'b1;
                    cw.a_load       = 1'b1;
                    cw.alu_subtract = (opcode == OPCODE_WIDTH'(OP_SUB));
`ifdef CONDITIONAL_JUMP_EN
                    cw.flags_load   = 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Micro-step sequencer: T-state register, stall/reset gating and strobe unpacking.
// Optional CONDITIONAL_JUMP_EN (see control_decoder) enables JC/JZ and the flags strobe.
module control_sequencer
    import xdn_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                    i_CLOCK,
    input  logic                    i_CLEAR_n,
    input  logic [OPCODE_WIDTH-1:0] i_OPCODE,
    input  logic                    i_FLAG_CARRY,
    input  logic                    i_FLAG_ZERO,
    input  logic                    i_STALL,
    output logic                    o_PC_COUNT_ENABLE,
    output logic                    o_PC_JUMP_n,
    output logic                    o_PC_OUTPUT_n,
    output logic                    o_MAR_LOAD_n,
    output logic                    o_RAM_LOAD_n,
    output logic                    o_RAM_OUTPUT_n,
    output logic                    o_IR_LOAD_n,
    output logic                    o_IR_OUTPUT_n,
    output logic                    o_A_LOAD_n,
    output logic                    o_A_OUTPUT_n,
    output logic                    o_B_LOAD_n,
    output logic                    o_ALU_OUTPUT_n,
    output logic                    o_FLAGS_LOAD_n,
    output logic                    o_OUT_LOAD_n,
    output logic                    o_ALU_SUBTRACT,
    output logic [2:0]              o_TSTATE,
    output logic                    o_HALTED
);

    localparam int unused_data_width = DATA_WIDTH;

    tstate_e    state_reg;
    tstate_e    state_next;
    logic       run_reg;
    logic       dec_last;
    logic       dec_halt;
    logic       strobe_active;
    ctrl_word_t dec_cw;
    ctrl_word_t cw;

    control_decoder #(
        .OPCODE_WIDTH(OPCODE_WIDTH)
    ) u_decoder (
        .state      (state_reg),
        .opcode     (i_OPCODE),
        .flag_carry (i_FLAG_CARRY),
        .flag_zero  (i_FLAG_ZERO),
        .cw         (dec_cw),
        .last       (dec_last),
        .halt       (dec_halt)
    );

    // run_reg keeps the partial cycle after reset release strobe-free, so the
    // first T0 step starts cleanly on the following rising edge.
    always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
        if (!i_CLEAR_n) begin
            state_reg <= T0;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            run_reg   <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (run_reg && !i_STALL)
            state_next = next_tstate(state_reg, dec_last, dec_halt);
    end

    assign strobe_active = i_CLEAR_n && run_reg && !i_STALL && (state_reg != THALT);
    assign cw            = strobe_active ? dec_cw : '0;

    assign o_PC_COUNT_ENABLE = cw.pc_count_enable;
    assign o_PC_JUMP_n       = ~cw.pc_jump;
    assign o_PC_OUTPUT_n     = ~cw.pc_output;
    assign o_MAR_LOAD_n      = ~cw.mar_load;
    assign o_RAM_LOAD_n      = ~cw.ram_load;
    assign o_RAM_OUTPUT_n    = ~cw.ram_output;
    assign o_IR_LOAD_n       = ~cw.ir_load;
    assign o_IR_OUTPUT_n     = ~cw.ir_output;
    assign o_A_LOAD_n        = ~cw.a_load;
    assign o_A_OUTPUT_n      = ~cw.a_output;
    assign o_B_LOAD_n        = ~cw.b_load;
    assign o_ALU_OUTPUT_n    = ~cw.alu_output;
    assign o_FLAGS_LOAD_n    = ~cw.flags_load;
    assign o_OUT_LOAD_n      = ~cw.out_load;
    assign o_ALU_SUBTRACT    = cw.alu_subtract;
    assign o_TSTATE          = state_reg;
    assign o_HALTED          = (state_reg == THALT);

endmodule
